// File: rtl/cpu_pkg.sv
// Shared opcode/funct, ALU and sequencer state encodings
// for the 64-bit CPU datapath.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLLV = 3'b101;
  localparam logic [2:0] ALU_SRLV = 3'b110;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC   = 4'd3;
  localparam logic [3:0] S_WB_ALU = 4'd4;
  localparam logic [3:0] S_MEM    = 4'd5;
  localparam logic [3:0] S_WB_MEM = 4'd6;
  localparam logic [3:0] S_BRANCH = 4'd7;
  localparam logic [3:0] S_HALT   = 4'd8;

  typedef struct packed {
    logic       alu_src;
    logic [2:0] alu_op;
  } alu_ctl_t;

  function automatic logic is_alu_op(
    input logic [5:0] op
  );
    return (op == OP_RTYPE) || (op == OP_ADDI) ||
           (op == OP_ANDI)  || (op == OP_ORI)  ||
           (op == OP_XORI);
  endfunction

  function automatic logic is_mem_op(
    input logic [5:0] op
  );
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Instruction/data memory request-ready handshake
// between the sequencer and the memory side.
interface mc_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/mc_alu_dec.sv
// Combinational opcode/funct -> ALU operation and
// operand-B select for ALU-class instructions.
module mc_alu_dec
  import cpu_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] fn_i,
  output alu_ctl_t   ctl_o
);

  logic [2:0] r_op;

  // Unknown funct falls back to ADD rather than trapping
  always_comb begin
    r_op = ALU_ADD;
    unique case (fn_i)
      FN_SUB:  r_op = ALU_SUB;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_XOR:  r_op = ALU_XOR;
      FN_SLLV: r_op = ALU_SLLV;
      FN_SRLV: r_op = ALU_SRLV;
      default: r_op = ALU_ADD;
    endcase
  end

  always_comb begin
    ctl_o.alu_src = 1'b1;
    ctl_o.alu_op  = ALU_ADD;
    unique case (1'b1)
      (op_i == OP_RTYPE): begin
        ctl_o.alu_src = 1'b0;
        ctl_o.alu_op  = r_op;
      end
      (op_i == OP_ANDI): ctl_o.alu_op = ALU_AND;
      (op_i == OP_ORI):  ctl_o.alu_op = ALU_OR;
      (op_i == OP_XORI): ctl_o.alu_op = ALU_XOR;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer.
// Optional memory-wait timeout: define MC_CTRL_TIMEOUT_EN.
module mc_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  mc_ctrl_if.master        mem,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             mem_to_reg,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             halted,
  output logic             bus_err,
  output logic [3:0]       state_o
);

  if (TIMEOUT_CYC < 1) begin : g_tmo_chk
    $error("TIMEOUT_CYC must be at least 1");
  end

  logic [3:0]       state_q, state_d;
  logic [5:0]       op_q, fn_q;
  logic [CNT_W-1:0] cnt_q;
  logic             imem_req, dmem_req, dmem_we;
  logic             tmo;
  alu_ctl_t         dec;

  mc_alu_dec u_dec (
    .op_i  (op_q),
    .fn_i  (fn_q),
    .ctl_o (dec)
  );

`ifdef MC_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] wait_q, wait_d;
  logic          waiting;
  logic          berr_q;

  assign waiting =
    ((state_q == S_FETCH) && !mem.imem_ready) ||
    ((state_q == S_MEM)   && !mem.dmem_ready);
  assign tmo = waiting && (wait_q == TMO_LAST);

  always_comb begin
    wait_d = '0;
    if (waiting && (state_d == state_q))
      wait_d = wait_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      berr_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      if (tmo) berr_q <= 1'b1;
    end
  end

  assign bus_err = berr_q;
`else
  assign tmo     = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    mem_to_reg = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (mem.imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          is_alu_op(opcode):  state_d = S_EXEC;
          is_mem_op(opcode):  state_d = S_MEM;
          (opcode == OP_BEQ): state_d = S_BRANCH;
          default:            state_d = S_HALT;
        endcase
      end
      S_EXEC: begin
        alu_src = dec.alu_src;
        alu_op  = dec.alu_op;
        state_d = S_WB_ALU;
      end
      S_WB_ALU: begin
        alu_src   = dec.alu_src;
        alu_op    = dec.alu_op;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEM: begin
        alu_src  = 1'b1;
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_SW);
        if (mem.dmem_ready) begin
          retire  = (op_q == OP_SW);
          state_d = (op_q == OP_SW) ? S_FETCH : S_WB_MEM;
        end
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_op   = ALU_SUB;
        retire   = 1'b1;
        pc_write = alu_zero;
        pc_src   = alu_zero;
        state_d  = S_FETCH;
      end
      S_HALT: ;
      // Unused encodings are treated as a fault
      default: state_d = S_HALT;
    endcase
    if (tmo) state_d = S_HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      fn_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign mem.imem_req = imem_req;
  assign mem.dmem_req = dmem_req;
  assign mem.dmem_we  = dmem_we;
  assign retired_cnt  = cnt_q;
  assign halted       = (state_q == S_HALT);
  assign state_o      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl.
// Build with MC_CTRL_TIMEOUT_EN to exercise the timeout.
module tb_mc_ctrl;
  import cpu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       alu_zero;
  logic       ir_write, pc_write, pc_src, reg_write;
  logic       alu_src, mem_to_reg, retire, halted, bus_err;
  logic [2:0] alu_op;
  logic [3:0] retired_cnt;
  logic [3:0] state_o;
  logic [3:0] exp_cnt;
  int         n_chk;
  int         n_fail;

  mc_ctrl_if mif();

  mc_ctrl #(.CNT_W(4), .TIMEOUT_CYC(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct       (funct),
    .alu_zero    (alu_zero),
    .mem         (mif),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .mem_to_reg  (mem_to_reg),
    .retire      (retire),
    .retired_cnt (retired_cnt),
    .halted      (halted),
    .bus_err     (bus_err),
    .state_o     (state_o)
  );

  // {state, imem_req, ir_write, pc_write, pc_src, dmem_req,
  //  dmem_we, reg_write, alu_src, alu_op, m2r, retire, halted, bus_err}
  logic [18:0] obs;
  assign obs = {state_o, mif.imem_req, ir_write, pc_write, pc_src,
                mif.dmem_req, mif.dmem_we, reg_write, alu_src,
                alu_op, mem_to_reg, retire, halted, bus_err};

  function automatic logic [18:0] ev(
    input logic [3:0] s,
    input logic [7:0] f,
    input logic [2:0] aop,
    input logic [3:0] g
  );
    return {s, f, aop, g};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    opcode = OP_RTYPE; funct = FN_ADD; alu_zero = 1'b0;
    mif.imem_ready = 1'b1; mif.dmem_ready = 1'b0;
    exp_cnt = '0;
    #12;
    n_chk++;
    if (obs !== '0) begin n_fail++;
      $display("FAIL reset_outs got %b want %b", obs, 19'b0); end
    n_chk++;
    if (retired_cnt !== 4'd0) begin n_fail++;
      $display("FAIL reset_cnt got %0d want 0", retired_cnt); end
    @(negedge clk); rst_n = 1'b1; #1;
    n_chk++;
    if (obs !== ev(4'd0, 8'b0, 3'b000, 4'b0)) begin n_fail++;
      $display("FAIL idle got %b", obs); end
    cyc(); #1;
    n_chk++;
    if (obs !== ev(4'd1, 8'b1110_0000, 3'b000, 4'b0)) begin n_fail++;
      $display("FAIL fetch_c1 got %b", obs); end
  endtask

  task automatic test_add();
    cyc(); #1;
    n_chk++;
    if (obs !== ev(4'd2, 8'b0, 3'b000, 4'b0)) begin n_fail++;
      $display("FAIL add_decode got %b", obs); end
    cyc(); #1;
    n_chk++;
    if (obs !== ev(4'd3, 8'b0, 3'b000, 4'b0)) begin n_fail++;
      $display("FAIL add_exec got %b", obs); end
    cyc(); #1;
    n_chk++;
    if (obs !== ev(4'd4, 8'b0000_0010, 3'b000, 4'b0100)) begin
      n_fail++; $display("FAIL add_wb got %b", obs); end
    exp_cnt++;
    cyc(); #1;
    n_chk++;
    if (retired_cnt !== exp_cnt) begin n_fail++;
      $display("FAIL add_cnt got %0d want %0d", retired_cnt, exp_cnt); end
  endtask

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic [2:0] aop;
    logic       src;
  } alu_vec_t;

  task automatic test_alu();
    alu_vec_t tv [11];
    tv[0]  = '{OP_RTYPE, FN_SUB,   3'b001, 1'b0};
    tv[1]  = '{OP_RTYPE, FN_AND,   3'b010, 1'b0};
    tv[2]  = '{OP_RTYPE, FN_OR,    3'b011, 1'b0};
    tv[3]  = '{OP_RTYPE, FN_XOR,   3'b100, 1'b0};
    tv[4]  = '{OP_RTYPE, FN_SLLV,  3'b101, 1'b0};
    tv[5]  = '{OP_RTYPE, FN_SRLV,  3'b110, 1'b0};
    tv[6]  = '{OP_RTYPE, 6'b111111, 3'b000, 1'b0};
    tv[7]  = '{OP_ANDI,  6'b000000, 3'b010, 1'b1};
    tv[8]  = '{OP_ORI,   6'b100010, 3'b011, 1'b1};
    tv[9]  = '{OP_XORI,  6'b000000, 3'b100, 1'b1};
    tv[10] = '{OP_ADDI,  6'b100100, 3'b000, 1'b1};
    for (int i = 0; i < 11; i++) begin
      opcode = tv[i].op; funct = tv[i].fn;
      cyc(); cyc(); #1;
      n_chk++;
      if (obs !== ev(4'd3, {7'b0, tv[i].src}, tv[i].aop, 4'b0)) begin
        n_fail++; $display("FAIL alu_exec[%0d] got %b", i, obs); end
      cyc(); #1;
      n_chk++;
      if (obs !== ev(4'd4, {6'b0, 1'b1, tv[i].src}, tv[i].aop,
                     4'b0100)) begin
        n_fail++; $display("FAIL alu_wb[%0d] got %b", i, obs); end
      exp_cnt++;
      cyc();
    end
    #1;
    n_chk++;
    if (retired_cnt !== exp_cnt) begin n_fail++;
      $display("FAIL alu_cnt got %0d want %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_lw();
    opcode = OP_LW; mif.dmem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      n_chk++;
      if (obs !== ev(4'd5, 8'b0000_1001, 3'b000, 4'b0)) begin
        n_fail++; $display("FAIL lw_wait[%0d] got %b", i, obs); end
    end
    cyc(); mif.dmem_ready = 1'b1; #1;
    n_chk++;
    if (obs !== ev(4'd5, 8'b0000_1001, 3'b000, 4'b0)) begin
      n_fail++; $display("FAIL lw_ready got %b", obs); end
    cyc(); mif.dmem_ready = 1'b0; #1;
    n_chk++;
    if (obs !== ev(4'd6, 8'b0000_0010, 3'b000, 4'b1100)) begin
      n_fail++; $display("FAIL lw_wbmem got %b", obs); end
    exp_cnt++;
    cyc(); #1;
    n_chk++;
    if (retired_cnt !== exp_cnt) begin n_fail++;
      $display("FAIL lw_cnt got %0d want %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_sw_beq();
    opcode = OP_SW; alu_zero = 1'b1; mif.dmem_ready = 1'b1;
    cyc(); cyc(); #1;
    n_chk++;
    if (obs !== ev(4'd5, 8'b0000_1101, 3'b000, 4'b0100)) begin
      n_fail++; $display("FAIL sw_mem got %b", obs); end
    exp_cnt++;
    cyc(); opcode = OP_BEQ; mif.dmem_ready = 1'b0; #1;
    n_chk++;
    if (obs !== ev(4'd1, 8'b1110_0000, 3'b000, 4'b0)) begin
      n_fail++; $display("FAIL sw_next_fetch got %b", obs); end
    cyc(); cyc(); #1;
    n_chk++;
    if (obs !== ev(4'd7, 8'b0011_0000, 3'b001, 4'b0100)) begin
      n_fail++; $display("FAIL beq_taken got %b", obs); end
    exp_cnt++;
    cyc(); alu_zero = 1'b0;
    cyc(); cyc(); #1;
    n_chk++;
    if (obs !== ev(4'd7, 8'b0, 3'b001, 4'b0100)) begin
      n_fail++; $display("FAIL beq_not_taken got %b", obs); end
    exp_cnt++;
    cyc(); #1;
    n_chk++;
    if (retired_cnt !== exp_cnt) begin n_fail++;
      $display("FAIL beq_cnt got %0d want %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_fetch_wait();
    mif.imem_ready = 1'b0; opcode = OP_ADDI; #1;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (obs !== ev(4'd1, 8'b1000_0000, 3'b000, 4'b0)) begin
        n_fail++; $display("FAIL fwait[%0d] got %b", i, obs); end
      cyc(); #1;
    end
    mif.imem_ready = 1'b1; #1;
    n_chk++;
    if (obs !== ev(4'd1, 8'b1110_0000, 3'b000, 4'b0)) begin
      n_fail++; $display("FAIL fwait_ready got %b", obs); end
    cyc(); cyc(); cyc(); exp_cnt++;
    cyc(); #1;
    n_chk++;
    if (retired_cnt !== exp_cnt) begin n_fail++;
      $display("FAIL fwait_cnt got %0d want %0d", retired_cnt, exp_cnt); end
  endtask

  task automatic test_halt();
    opcode = 6'b111111;
    cyc(); cyc(); #1;
    for (int i = 0; i < 20; i++) begin
      n_chk++;
      if (obs !== ev(4'd8, 8'b0, 3'b000, 4'b0010)) begin
        n_fail++; $display("FAIL halt[%0d] got %b", i, obs); end
      cyc(); #1;
    end
  endtask

  task automatic test_reset_mid_mem();
    rst_n = 1'b0; #2;
    @(negedge clk); rst_n = 1'b1;
    exp_cnt = '0; opcode = OP_LW; mif.dmem_ready = 1'b0;
    cyc(); cyc(); cyc(); #1;
    n_chk++;
    if (obs !== ev(4'd5, 8'b0000_1001, 3'b000, 4'b0)) begin
      n_fail++; $display("FAIL rst_pre_mem got %b", obs); end
    #1; rst_n = 1'b0; #1;
    n_chk++;
    if (obs !== '0) begin n_fail++;
      $display("FAIL rst_mid_mem got %b want 0", obs); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    exp_cnt = '0; opcode = OP_ADDI; funct = 6'b0;
    mif.imem_ready = 1'b1;
    cyc();
    for (int i = 0; i < 16; i++) begin
      cyc(); cyc(); cyc(); #1;
      n_chk++;
      if (obs !== ev(4'd4, 8'b0000_0011, 3'b000, 4'b0100)) begin
        n_fail++; $display("FAIL wrap_wb[%0d] got %b", i, obs); end
      cyc(); #1;
      if (i == 14) begin
        n_chk++;
        if (retired_cnt !== 4'd15) begin n_fail++;
          $display("FAIL wrap_15 got %0d want 15", retired_cnt); end
      end
    end
    n_chk++;
    if (retired_cnt !== 4'd0) begin n_fail++;
      $display("FAIL wrap_0 got %0d want 0", retired_cnt); end
  endtask

`ifdef MC_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    rst_n = 1'b0; #3;
    @(negedge clk); rst_n = 1'b1; mif.imem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 8; i++) begin
      #1;
      n_chk++;
      if (obs !== ev(4'd1, 8'b1000_0000, 3'b000, 4'b0)) begin
        n_fail++; $display("FAIL tmo_wait[%0d] got %b", i, obs); end
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (obs !== ev(4'd8, 8'b0, 3'b000, 4'b0011)) begin
        n_fail++; $display("FAIL tmo_halt[%0d] got %b", i, obs); end
      cyc();
    end
  endtask
`else
  task automatic test_timeout();
    rst_n = 1'b0; #3;
    @(negedge clk); rst_n = 1'b1; mif.imem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 20; i++) begin
      #1;
      n_chk++;
      if (obs !== ev(4'd1, 8'b1000_0000, 3'b000, 4'b0)) begin
        n_fail++; $display("FAIL no_tmo[%0d] got %b", i, obs); end
      cyc();
    end
  endtask
`endif

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_add();
    test_alu();
    test_lw();
    test_sw_beq();
    test_fetch_wait();
    test_halt();
    test_reset_mid_mem();
    test_wrap();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle sequencer for the 64-bit CPU datapath: fetch, decode, execute, memory and writeback phases over several cycles, one instruction at a time.
Drives the same control set as the single-cycle decoder (reg_write, alu_src, alu_op, mem_to_reg), plus PC/IR enables and imem/dmem request/ready handshakes.
Sits between the instruction register and the shared ALU/regfile/memory datapath.

Parameters:
CNT_W, 32, width of retired-instruction counter
TIMEOUT_CYC, 64, memory-wait limit in cycles (used only with MC_CTRL_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
alu_zero  in  1  ALU zero flag
imem_ready  in  1  instruction memory ready
dmem_ready  in  1  data memory ready
imem_req  out  1  instruction fetch request
ir_write  out  1  IR load enable
pc_write  out  1  PC load enable
pc_src  out  1  0=PC+4, 1=branch target
dmem_req  out  1  data memory request
dmem_we  out  1  1=store
reg_write  out  1  regfile write enable
alu_src  out  1  0=rs2, 1=imm
alu_op  out  3  000 ADD,001 SUB,010 AND,011 OR,100 XOR,101 SLLV,110 SRLV
mem_to_reg  out  1  0=ALU, 1=mem data
retire  out  1  one-cycle pulse on instruction completion
retired_cnt  out  CNT_W  completed-instruction count
halted  out  1  illegal opcode (or bus error) stop
bus_err  out  1  memory timeout flag (0 without MC_CTRL_TIMEOUT_EN)
state_o  out  4  current state, debug

Behaviour:
- Clock and reset: single clock clk; reset rst_n asynchronous, active-low. All state asynchronously cleared.
- Reset values: state=IDLE, every output 0, retired_cnt=0.
- Outputs are Moore-decoded from state plus the latched opcode/funct. Exceptions: ir_write, pc_write, pc_src, retire also depend on the ready/zero inputs in the current cycle.
- States (state_o encoding): IDLE 0, FETCH 1, DECODE 2, EXEC 3, WB_ALU 4, MEM 5, WB_MEM 6, BRANCH 7, HALT 8.
- IDLE: always -> FETCH next cycle. Gives a clean output-zero cycle after reset release.
- FETCH: imem_req=1, held until imem_ready. Ready is sampled the same cycle, so zero-wait gives a 1-cycle fetch. On ready: ir_write=1, pc_write=1, pc_src=0, -> DECODE.
- DECODE: latch opcode/funct into internal registers. Next state by opcode:
  - R (000000), ADDI 001000, ANDI 001100, ORI 001101, XORI 001110 -> EXEC
  - LW 100011, SW 101011 -> MEM
  - BEQ 000100 -> BRANCH
  - any other -> HALT
- ALU control from latched fields:
  - R-type: funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 000100 SLLV, 000110 SRLV; unknown funct -> ADD (no trap).
  - I-type: ADDI=ADD, ANDI=AND, ORI=OR, XORI=XOR.
- EXEC: alu_src=1 for I-type, 0 for R; alu_op per decode; -> WB_ALU.
- WB_ALU: same alu_src/alu_op held; reg_write=1, mem_to_reg=0, retire=1; -> FETCH.
- MEM: alu_src=1, alu_op=ADD, dmem_req=1, dmem_we=1 for SW; held until dmem_ready. On ready: LW -> WB_MEM; SW -> retire=1, -> FETCH.
- WB_MEM: reg_write=1, mem_to_reg=1, retire=1; -> FETCH.
- BRANCH: alu_src=0, alu_op=SUB, retire=1. If alu_zero: pc_write=1, pc_src=1. -> FETCH.
- HALT: halted=1, all other outputs 0; stays until reset.
- Zero-wait latency: R/I 4 cycles, LW 4, SW 3, BEQ 3.
- retired_cnt increments on retire, wraps modulo 2^CNT_W.
- Reset mid-operation: immediate return to IDLE; requests drop asynchronously.
- reg_write and dmem_we are never asserted in the same cycle.

Optional Feature:
MC_CTRL_TIMEOUT_EN: wait counter counts cycles with imem_req or dmem_req high and ready low. Cleared on ready or on state change.
- With the macro: when the count reaches TIMEOUT_CYC, go to HALT, set bus_err=1 and halted=1 (both sticky until reset).
- Without the macro: no counter, waits indefinitely, bus_err tied 0.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode and funct localparams
  - 3-bit alu_op encodings
  - 4-bit state encodings
- One natural sub-module, mc_alu_dec: combinational opcode/funct -> alu_op, alu_src. It replaces the duplicated table.
- The FSM, counters and timeout stay in mc_ctrl.

Test Plan:
- Reset release, imem_ready=1 constant -> state IDLE,FETCH; ir_write and pc_write pulse in cycle 1; all outputs 0 during reset.
- ADD R-type (funct 100000), zero-wait -> EXEC alu_op=000 alu_src=0; WB_ALU reg_write=1; retire at cycle 4; retired_cnt=1.
- LW, dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0; WB_MEM mem_to_reg=1, reg_write=1.
- SW then BEQ: SW with alu_zero=1 -> dmem_we=1, no reg_write; BEQ -> pc_write=1 pc_src=1 alu_op=001. Repeat BEQ with alu_zero=0 -> pc_write=0.
- Opcode 111111 -> HALT, halted=1, imem_req stays 0 for 20 cycles; rst_n pulse mid-MEM -> all outputs 0 immediately.
- With MC_CTRL_TIMEOUT_EN, TIMEOUT_CYC=8, imem_ready=0 -> bus_err=1 and halted=1 after 8 wait cycles; CNT_W=4, 16 ADDI -> retired_cnt wraps to 0.
